// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master drives the request and operands; the slave (the subtractor) returns status and results.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] input_A;
  logic [WIDTH-1:0] input_B;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] output_D;
  logic             borrow_Out;
  logic             overflow;

  modport master (
    output start, input_A, input_B, borrow_in,
    input  busy, done, output_D, borrow_Out, overflow
  );

  modport slave (
    input  start, input_A, input_B, borrow_in,
    output busy, done, output_D, borrow_Out, overflow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - borrow_in, one bit per clock, LSB first.
// A single full-subtractor cell walks two shift registers; results are held until the next completion.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  serial_subtractor_if.slave        bus
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] out_d_q, out_d_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  // Full-subtractor cell operating on the current LSBs.
  logic             a_bit, b_bit, d_bit, br_next;
  logic [WIDTH-1:0] res_shift;

  always_comb begin
    a_bit     = a_sr_q[0];
    b_bit     = b_sr_q[0];
    d_bit     = a_bit ^ b_bit ^ br_q;
    br_next   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    res_shift = {d_bit, res_q[WIDTH-1:1]};
  end

  // Next-state: accept in idle, shift one bit per cycle in run, publish results on the last bit.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    out_d_d = out_d_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRun;
          a_sr_d  = bus.input_A;
          b_sr_d  = bus.input_B;
          br_d    = bus.borrow_in;
          cnt_d   = '0;
          a_msb_d = bus.input_A[WIDTH-1];
          b_msb_d = bus.input_B[WIDTH-1];
          busy_d  = 1'b1;
        end
      end
      StRun: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        res_d  = res_shift;
        br_d   = br_next;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          // d_bit here is the MSB of the difference.
          state_d = StIdle;
          out_d_d = res_shift;
          bout_d  = br_next;
          ovf_d   = (a_msb_q != b_msb_q) & (d_bit != a_msb_q);
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any operation in flight and clears the outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_d_q <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_d_q <= out_d_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.output_D   = out_d_q;
  assign bus.borrow_Out = bout_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor with a result scoreboard.
module tb_serial_subtractor;
  localparam int W = 4;

  logic clock = 1'b0;
  logic reset;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } res_t;

  res_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: wide unsigned subtraction for D/borrow, signed integer range test for overflow.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    res_t       r;
    logic [W:0] full;
    int         s;
    full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    r.d  = full[W-1:0];
    r.bo = full[W];
    s    = int'($signed(a)) - int'($signed(b)) - int'(bin);
    r.ov = (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
    return r;
  endfunction

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clock) begin
    if (!reset && bus.done) begin
      res_t e;
      if (sb_q.size() == 0) begin
        check("done_without_op", bus.done, 1'b0);
      end else begin
        e = sb_q.pop_front();
        check("output_D", bus.output_D, e.d);
        check("borrow_Out", bus.borrow_Out, e.bo);
        check("overflow", bus.overflow, e.ov);
      end
    end
  end

  task automatic drive(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    bus.start     = s;
    bus.input_A   = a;
    bus.input_B   = b;
    bus.borrow_in = bin;
  endtask

  // Wait (bounded) for done, checking busy every cycle; returns cycles waited.
  task automatic wait_done(output int n);
    bit got;
    n   = 0;
    got = 0;
    while (!got && n < 20) begin
      @(posedge clock);
      #1;
      n++;
      if (bus.done) got = 1;
      else check("busy_during_run", bus.busy, 1'b1);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int n;
    @(negedge clock);
    drive(1'b1, a, b, bin);
    sb_q.push_back(model(a, b, bin));
    @(posedge clock);
    #1;
    drive(1'b0, 'x, 'x, 1'bx);
    check("busy_after_accept", bus.busy, 1'b1);
    wait_done(n);
    check("latency", n, W);
    check("busy_at_done", bus.busy, 1'b0);
    @(posedge clock);
    #1;
    check("done_one_cycle", bus.done, 1'b0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_output_D", bus.output_D, '0);
    check("reset_borrow_Out", bus.borrow_Out, 1'b0);
    check("reset_overflow", bus.overflow, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    run_op(4'd9, 4'd3, 1'b0);
    run_op(4'd3, 4'd9, 1'b0);
    run_op(4'd0, 4'd0, 1'b1);
    run_op(4'd7, 4'd8, 1'b0);
    run_op(4'd5, 4'd9, 1'b1);

    // Start ignored while busy, then back-to-back accept during the done cycle.
    @(negedge clock);
    drive(1'b1, 4'd9, 4'd3, 1'b0);
    sb_q.push_back(model(4'd9, 4'd3, 1'b0));
    @(posedge clock);
    #1;
    drive(1'b0, 'x, 'x, 1'bx);
    @(posedge clock);
    #1;
    drive(1'b1, 4'd1, 4'd1, 1'b0);
    @(posedge clock);
    #1;
    drive(1'b0, 'x, 'x, 1'bx);
    check("ignored_start_busy", bus.busy, 1'b1);
    @(posedge clock);
    #1;
    check("not_done_early", bus.done, 1'b0);
    @(posedge clock);
    #1;
    check("done_after_ignored", bus.done, 1'b1);
    check("result_ignores_start", bus.output_D, 4'd6);
    drive(1'b1, 4'd5, 4'd5, 1'b0);
    sb_q.push_back(model(4'd5, 4'd5, 1'b0));
    @(posedge clock);
    #1;
    drive(1'b0, 'x, 'x, 1'bx);
    check("b2b_accepted", bus.busy, 1'b1);
    begin
      bit got;
      n   = 0;
      got = 0;
      while (!got && n < 20) begin
        check("hold_output_D", bus.output_D, 4'd6);
        @(posedge clock);
        #1;
        n++;
        if (bus.done) got = 1;
      end
    end
    check("b2b_latency", n, W);
    @(posedge clock);

    // Nonzero result first so the reset clear is observable.
    run_op(4'd15, 4'd1, 1'b0);
    @(negedge clock);
    drive(1'b1, 4'd12, 4'd4, 1'b0);
    @(posedge clock);
    #1;
    drive(1'b0, 'x, 'x, 1'bx);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_output_D", bus.output_D, '0);
    check("abort_borrow_Out", bus.borrow_Out, 1'b0);
    check("abort_overflow", bus.overflow, 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (6) begin
      @(posedge clock);
      #1;
      check("no_done_after_abort", bus.done, 1'b0);
    end
    run_op(4'd12, 4'd4, 1'b0);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
